rx_frame_unpacker: RTL and testbench
====================================

// Module: rx_frame_unpacker
// PURPOSE
//  Drains the 27-bit receiver FIFO (three {k,byte} symbols per word) and rebuilds chip frames.
//  Strips idle and frame K-codes, packs payload bytes MSB-first into 32-bit words, and tags
//  frame start/end. Optionally emits a TIMESTAMP word at each SOF.
//  Sits between the receiver FIFO and the readout data-word formatter, on FIFO_CLK.
// PARAMETERS
//  MAX_BYTES  256  payload bytes per frame; beyond this the frame is truncated.
//  TS_EN      1    1: emit a timestamp word before the first data word of each frame.
// PORTS
//  FIFO_CLK        in   1   sole clock.
//  RESET           in   1   asynchronous, active-high reset.
//  enable          in   1   0: no FIFO reads, FSM holds its state.
//  fifo_data       in   27  {sym0,sym1,sym2}; sym0=[26:18] is first in time; sym={k,byte[7:0]}.
//  fifo_empty      in   1   first-word-fall-through: fifo_data is valid while low.
//  fifo_read       out  1   pops one word.
//  TIMESTAMP       in   27  free-running timestamp, sampled at SOF.
//  out_data        out  32  packed payload, or {5'b0,TIMESTAMP} when out_ts=1.
//  out_nbytes      out  3   valid bytes in out_data (1..4), left-aligned; unused low bytes are 0.
//  out_sof/out_eof out  1   first / last data word of a frame.
//  out_ts          out  1   word is a timestamp.
//  out_err         out  1   frame closed abnormally (truncated, restarted or bad K).
//  out_valid       out  1   with out_ready forms a valid/ready handshake.
//  out_ready       in   1
//  frame_cnt       out  16  frames closed; saturates at 0xFFFF.
//  err_cnt         out  8   protocol errors; saturates at 0xFF.
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; symbol index 0; holding register empty.
//  Symbol K-codes: SOF 0xFC/0xBC, EOF 0x5C/0x7C, IDLE 0x3C; any other K is BADK.
//  Input
//   - Reading a word: fifo_read=1 when enable & !fifo_empty & (holding empty | last symbol being consumed).
//   - Consumption: one symbol per cycle from the holding register, sym0 to sym2, unless stalled.
//   - Stall: out_valid & !out_ready while the current symbol needs to emit a word.
//  FSM states: IDLE, FRAME, DROP.
//   - IDLE:  SOF -> latch TIMESTAMP, emit TS word (if TS_EN), go to FRAME.
//            Data byte, EOF or BADK -> err_cnt++, stay.
//   - FRAME: data byte -> shift into the pack register and increment the byte count.
//            At 4 bytes, emit a word (out_sof on the first word of the frame).
//            EOF -> flush the partial word (or mark the last full word) with out_eof=1 -> IDLE, frame_cnt++.
//            EOF with no payload -> one word: nbytes=1, data=0, out_eof=1, out_err=1.
//            SOF -> close the current frame (eof=1, err=1), err_cnt++, then open a new one.
//            BADK -> err_cnt++, close with err=1 -> DROP.
//            Byte MAX_BYTES+1 -> close with err=1 -> DROP.
//   - DROP:  discard until EOF (-> IDLE) or SOF (-> FRAME, new frame).
//  Simultaneous events
//   - A close plus a new SOF needs two output words: stall one cycle on that symbol.
//   - Counter increments coincide at most one per cycle per counter.
//  Output register: loads only when !out_valid | out_ready; holds stable while stalled.
//  Latency: 1 cycle from consuming a symbol to the word appearing on out_*.
//  enable=0 mid-frame: consumption stops and state is kept; resumes without loss.
//  RESET mid-frame: the partial frame is discarded and nothing further is emitted.
// STRUCTURE
//  Shared package: K-code constants, the 9-bit symbol typedef, FSM state encoding.
//  Sub-module: rx_byte_packer (4-byte pack register, byte count, flush/pad logic).
//  Top level: holding register, symbol index, FSM, counters.
// TESTING
//  1 Word {SOF,0x12,0x34},{0x56,0x78,0x9A},{EOF,IDLE,IDLE}, TS_EN=1, TIMESTAMP=0x100 ->
//    TS word 0x00000100; 0x12345678 sof; 0x9A000000 nbytes=1 eof; frame_cnt=1.
//  2 Same frame with out_ready toggled every other cycle ->
//    identical word sequence, no duplicates, out_data stable while stalled.
//  3 SOF, 3 bytes, SOF, 4 bytes, EOF ->
//    first frame closes with nbytes=3, eof=1, err=1; second frame clean; err_cnt=1, frame_cnt=2.
//  4 MAX_BYTES=8, frame with 10 bytes -> 2 words, second has eof=1, err=1;
//    remaining bytes dropped; next frame is normal.
//  5 Data bytes and EOF with no SOF, plus a K 0x1C -> nothing emitted; err_cnt=3.
//    Also: 300 errors -> err_cnt stays at 0xFF.
//  6 RESET asserted between two words of a frame -> all outputs 0 immediately;
//    the next complete frame is decoded correctly.

Source files
------------

// File: rtl/rx_frame_unpacker_pkg.sv
// Shared definitions for the receiver frame unpacker: K-code values,
// the 9-bit {k,byte} symbol type, symbol classification and FSM encoding.
package rx_frame_unpacker_pkg;

    typedef logic [8:0] sym_t;

    localparam logic [7:0] K_SOF_A = 8'hFC;
    localparam logic [7:0] K_SOF_B = 8'hBC;
    localparam logic [7:0] K_EOF_A = 8'h5C;
    localparam logic [7:0] K_EOF_B = 8'h7C;
    localparam logic [7:0] K_IDLE  = 8'h3C;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SK_DATA = 3'd0,
        SK_SOF  = 3'd1,
        SK_EOF  = 3'd2,
        SK_IDLE = 3'd3,
        SK_BADK = 3'd4
    } sym_kind_t;

    // Map a raw symbol onto the handful of meanings the FSM cares about.
    function automatic sym_kind_t classify(input sym_t s);
        sym_kind_t k;
        if (!s[8]) begin
            k = SK_DATA;
        end else begin
            case (s[7:0])
                K_SOF_A, K_SOF_B: k = SK_SOF;
                K_EOF_A, K_EOF_B: k = SK_EOF;
                K_IDLE:           k = SK_IDLE;
                default:          k = SK_BADK;
            endcase
        end
        return k;
    endfunction

endpackage

// File: rtl/rx_frame_unpacker_packer.sv
// Four-byte pack register: collects payload bytes MSB-first and reports
// how many are held. A push while full (or together with clr) starts a
// fresh word with the incoming byte, so the caller can emit the old full
// word and keep accepting bytes in the same cycle.
module rx_byte_packer (
    input  logic        WCLK,
    input  logic        RESET,
    input  logic        clr,
    input  logic        push,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic [2:0]  count,
    output logic        full,
    output logic        empty,
    output logic [2:0]  flush_nbytes
);

    assign full  = (count == 3'd4);
    assign empty = (count == 3'd0);
    // An empty flush still produces a one-byte zero word.
    assign flush_nbytes = empty ? 3'd1 : count;

    // Pack register and byte count; unused low bytes always stay zero.
    always_ff @(posedge WCLK or posedge RESET) begin
        if (RESET) begin
            word  <= '0;
            count <= '0;
        end else if (push) begin
            if (clr || full) begin
                word  <= {byte_in, 24'h000000};
                count <= 3'd1;
            end else begin
                case (count[1:0])
                    2'd0:    word[31:24] <= byte_in;
                    2'd1:    word[23:16] <= byte_in;
                    2'd2:    word[15:8]  <= byte_in;
                    default: word[7:0]   <= byte_in;
                endcase
                count <= count + 3'd1;
            end
        end else if (clr) begin
            word  <= '0;
            count <= '0;
        end
    end

endmodule

// File: rtl/rx_frame_unpacker.sv
// Drains the 27-bit receiver FIFO (three {k,byte} symbols per word),
// strips K-codes and rebuilds frames as packed 32-bit words tagged with
// sof/eof/err, optionally preceded by a timestamp word.
//
// Output handshake: a word transfers on a FIFO_CLK edge where
// out_valid && out_ready; once out_valid is high, out_* stay stable until
// that transfer, and out_valid never drops without one.
//
// A full word is held in the packer until the next symbol arrives, so an
// EOF right after the fourth byte can still mark that word as the last.
module rx_frame_unpacker
    import rx_frame_unpacker_pkg::*;
#(
    parameter int MAX_BYTES = 256,
    parameter bit TS_EN     = 1'b1
) (
    input  logic        FIFO_CLK,
    input  logic        RESET,
    input  logic        enable,
    input  logic [26:0] fifo_data,
    input  logic        fifo_empty,
    output logic        fifo_read,
    input  logic [26:0] TIMESTAMP,
    output logic [31:0] out_data,
    output logic [2:0]  out_nbytes,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_ts,
    output logic        out_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt,
    output state_t      dbg_state
);

    localparam int TOT_W = $clog2(MAX_BYTES + 1);
    localparam logic [TOT_W-1:0] MAX_T = TOT_W'(MAX_BYTES);

    state_t      state, state_nxt;
    logic [26:0] hold_data;
    logic        hold_valid;
    logic [1:0]  sym_idx;
    logic        first_word, first_nxt;
    logic [TOT_W-1:0] total, total_nxt;

    sym_t        sym;
    sym_kind_t   kind;
    logic        need_emit, advance, close_word;
    logic        pk_clr, pk_push, inc_frame, inc_err;
    logic [31:0] w_data;
    logic [2:0]  w_nbytes;
    logic        w_sof, w_eof, w_ts, w_err;
    logic        have_sym, out_free, go, consumed, last_consumed;

    logic [31:0] pk_word;
    logic [2:0]  pk_count, pk_flush_nbytes;
    logic        pk_full, pk_empty;

    rx_byte_packer u_packer (
        .WCLK         (FIFO_CLK),
        .RESET        (RESET),
        .clr          (pk_clr & go),
        .push         (pk_push & go),
        .byte_in      (sym[7:0]),
        .word         (pk_word),
        .count        (pk_count),
        .full         (pk_full),
        .empty        (pk_empty),
        .flush_nbytes (pk_flush_nbytes)
    );

    assign dbg_state = state;

    // Select the symbol currently being looked at, sym0 first in time.
    always_comb begin
        case (sym_idx)
            2'd0:    sym = hold_data[26:18];
            2'd1:    sym = hold_data[17:9];
            default: sym = hold_data[8:0];
        endcase
    end

    assign kind = classify(sym);

    // Per-symbol decision: next state, packer action, word to emit, counter bumps.
    always_comb begin
        state_nxt  = state;
        first_nxt  = first_word;
        total_nxt  = total;
        need_emit  = 1'b0;
        advance    = 1'b1;
        close_word = 1'b0;
        pk_clr     = 1'b0;
        pk_push    = 1'b0;
        inc_frame  = 1'b0;
        inc_err    = 1'b0;
        w_data     = '0;
        w_nbytes   = '0;
        w_sof      = 1'b0;
        w_eof      = 1'b0;
        w_ts       = 1'b0;
        w_err      = 1'b0;
        case (state)
            ST_FRAME: begin
                case (kind)
                    SK_DATA: begin
                        if (total == MAX_T) begin
                            close_word = 1'b1;
                            w_err      = 1'b1;
                            state_nxt  = ST_DROP;
                        end else begin
                            pk_push   = 1'b1;
                            total_nxt = total + TOT_W'(1);
                            if (pk_full) begin
                                need_emit = 1'b1;
                                w_data    = pk_word;
                                w_nbytes  = 3'd4;
                                w_sof     = first_word;
                                first_nxt = 1'b0;
                            end
                        end
                    end
                    SK_EOF: begin
                        close_word = 1'b1;
                        w_err      = pk_empty;
                        state_nxt  = ST_IDLE;
                    end
                    SK_SOF: begin
                        // Close now, reprocess the same SOF next cycle from IDLE.
                        close_word = 1'b1;
                        w_err      = 1'b1;
                        inc_err    = 1'b1;
                        advance    = 1'b0;
                        state_nxt  = ST_IDLE;
                    end
                    SK_BADK: begin
                        close_word = 1'b1;
                        w_err      = 1'b1;
                        inc_err    = 1'b1;
                        state_nxt  = ST_DROP;
                    end
                    default: ;
                endcase
                if (close_word) begin
                    need_emit = 1'b1;
                    w_data    = pk_word;
                    w_nbytes  = pk_flush_nbytes;
                    w_sof     = first_word;
                    w_eof     = 1'b1;
                    pk_clr    = 1'b1;
                    inc_frame = 1'b1;
                end
            end
            default: begin
                if (kind == SK_SOF) begin
                    state_nxt = ST_FRAME;
                    pk_clr    = 1'b1;
                    total_nxt = '0;
                    first_nxt = 1'b1;
                    if (TS_EN) begin
                        need_emit = 1'b1;
                        w_ts      = 1'b1;
                        w_data    = {5'b0, TIMESTAMP};
                        w_nbytes  = 3'd4;
                    end
                end else if (kind == SK_EOF) begin
                    state_nxt = ST_IDLE;
                    inc_err   = (state != ST_DROP);
                end else if (state != ST_DROP && kind != SK_IDLE) begin
                    inc_err = 1'b1;
                end
            end
        endcase
    end

    assign have_sym      = enable & hold_valid;
    assign out_free      = ~out_valid | out_ready;
    assign go            = have_sym & (~need_emit | out_free);
    assign consumed      = go & advance;
    assign last_consumed = consumed & (sym_idx == 2'd2);
    // A pop is never issued while the block is held in reset.
    assign fifo_read     = ~RESET & enable & ~fifo_empty & (~hold_valid | last_consumed);

    // Holding register and symbol index.
    always_ff @(posedge FIFO_CLK or posedge RESET) begin
        if (RESET) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
            sym_idx    <= 2'd0;
        end else if (fifo_read) begin
            hold_data  <= fifo_data;
            hold_valid <= 1'b1;
            sym_idx    <= 2'd0;
        end else if (last_consumed) begin
            hold_valid <= 1'b0;
            sym_idx    <= 2'd0;
        end else if (consumed) begin
            sym_idx    <= sym_idx + 2'd1;
        end
    end

    // FSM state and per-frame bookkeeping advance only when the symbol is processed.
    always_ff @(posedge FIFO_CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            first_word <= 1'b0;
            total      <= '0;
        end else if (go) begin
            state      <= state_nxt;
            first_word <= first_nxt;
            total      <= total_nxt;
        end
    end

    // Saturating frame and error counters.
    always_ff @(posedge FIFO_CLK or posedge RESET) begin
        if (RESET) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (go && inc_frame && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
            if (go && inc_err && err_cnt != 8'hFF)        err_cnt   <= err_cnt + 8'd1;
        end
    end

    // Output register: loads a new word only when empty or being taken this cycle.
    always_ff @(posedge FIFO_CLK or posedge RESET) begin
        if (RESET) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_nbytes <= '0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            out_ts     <= 1'b0;
            out_err    <= 1'b0;
        end else if (go && need_emit) begin
            out_valid  <= 1'b1;
            out_data   <= w_data;
            out_nbytes <= w_nbytes;
            out_sof    <= w_sof;
            out_eof    <= w_eof;
            out_ts     <= w_ts;
            out_err    <= w_err;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_frame_unpacker.sv
// Directed bench for rx_frame_unpacker (MAX_BYTES=8, TS_EN=1).
module tb_rx_frame_unpacker;
    import rx_frame_unpacker_pkg::*;

    localparam int W = 39;  // {data[31:0], nbytes[2:0], sof, eof, ts, err}

    logic        FIFO_CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        enable = 1'b0;
    logic [26:0] fifo_data = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_read;
    logic [26:0] TIMESTAMP = '0;
    logic [31:0] out_data;
    logic [2:0]  out_nbytes;
    logic        out_sof, out_eof, out_ts, out_err, out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;
    state_t      dbg_state;

    logic [26:0]  fifo_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    int           ready_mode = 0;
    int           stall_viol = 0;
    int           n_checks = 0;
    int           n_pass = 0;

    rx_frame_unpacker #(.MAX_BYTES(8), .TS_EN(1'b1)) dut (
        .FIFO_CLK   (FIFO_CLK),
        .RESET      (RESET),
        .enable     (enable),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_read  (fifo_read),
        .TIMESTAMP  (TIMESTAMP),
        .out_data   (out_data),
        .out_nbytes (out_nbytes),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .out_ts     (out_ts),
        .out_err    (out_err),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 FIFO_CLK = ~FIFO_CLK;

    // ---------------- FIFO model (first-word-fall-through) ----------------
    logic popping;
    always begin
        @(posedge FIFO_CLK);
        popping = fifo_read;
        #1;
        if (popping && fifo_q.size() != 0) void'(fifo_q.pop_front());
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 27'h0 : fifo_q[0];
    end

    // out_ready: mode 0 always high, mode 1 toggles every cycle
    always begin
        @(posedge FIFO_CLK);
        #1;
        if (ready_mode == 1) out_ready = ~out_ready;
        else                 out_ready = 1'b1;
    end

    // ---------------- output monitor ----------------
    logic [W-1:0] cur_w, prev_w;
    logic         prev_stall = 1'b0;
    always @(negedge FIFO_CLK) begin
        cur_w = {out_data, out_nbytes, out_sof, out_eof, out_ts, out_err};
        if (RESET) begin
            prev_stall = 1'b0;
        end else begin
            if (out_valid && out_ready) obs_q.push_back(cur_w);
            if (prev_stall && (!out_valid || cur_w !== prev_w)) stall_viol++;
            prev_stall = out_valid && !out_ready;
            prev_w = cur_w;
        end
    end

    // ---------------- helpers ----------------
    function automatic sym_t kd(input logic [7:0] c);
        return {1'b1, c};
    endfunction

    function automatic sym_t dd(input logic [7:0] b);
        return {1'b0, b};
    endfunction

    function automatic logic [26:0] wd(input sym_t a, input sym_t b, input sym_t c);
        return {a, b, c};
    endfunction

    function automatic logic [W-1:0] ew(input logic [31:0] d, input logic [2:0] n,
                                        input logic sof, input logic eof,
                                        input logic ts, input logic err);
        return {d, n, sof, eof, ts, err};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge FIFO_CLK);
        #2;
    endtask

    task automatic push_word(input logic [26:0] w);
        fifo_q.push_back(w);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        enable = 1'b0;
        ready_mode = 0;
        fifo_q.delete();
        tick(3);
        RESET = 1'b0;
        obs_q.delete();
        exp_q.delete();
        stall_viol = 0;
        tick(1);
    endtask

    task automatic push_basic_frame();
        push_word(wd(kd(8'hFC), dd(8'h12), dd(8'h34)));
        push_word(wd(dd(8'h56), dd(8'h78), dd(8'h9A)));
        push_word(wd(kd(8'h5C), kd(8'h3C), kd(8'h3C)));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RESET = 1'b1;
        tick(2);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else n_pass++;
        n_checks++; if ({out_data, out_nbytes, out_sof, out_eof, out_ts, out_err} !== '0)
            $display("FAIL reset_word got=%h exp=0", {out_data, out_nbytes, out_sof, out_eof, out_ts, out_err}); else n_pass++;
        n_checks++; if (frame_cnt !== 16'h0 || err_cnt !== 8'h0)
            $display("FAIL reset_cnt got=%h/%h exp=0/0", frame_cnt, err_cnt); else n_pass++;
        n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL reset_state got=%0d exp=0", dbg_state); else n_pass++;
        do_reset();
    endtask

    task automatic test_single_frame();
        logic [W-1:0] got;
        do_reset();
        TIMESTAMP = 27'h100;
        enable = 1'b1;
        push_basic_frame();
        tick(30);
        exp_q = '{ew(32'h00000100, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0),
                  ew(32'h12345678, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0),
                  ew(32'h9A000000, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0)};
        n_checks++; if (obs_q.size() !== exp_q.size())
            $display("FAIL single_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            got = 'x; if (i < obs_q.size()) got = obs_q[i];
            n_checks++; if (got !== exp_q[i]) $display("FAIL single_word%0d got=%h exp=%h", i, got, exp_q[i]); else n_pass++;
        end
        n_checks++; if (frame_cnt !== 16'd1) $display("FAIL single_frame_cnt got=%0d exp=1", frame_cnt); else n_pass++;
        n_checks++; if (err_cnt !== 8'd0) $display("FAIL single_err_cnt got=%0d exp=0", err_cnt); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] got;
        do_reset();
        TIMESTAMP = 27'h100;
        ready_mode = 1;
        enable = 1'b1;
        push_basic_frame();
        tick(40);
        ready_mode = 0;
        tick(4);
        exp_q = '{ew(32'h00000100, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0),
                  ew(32'h12345678, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0),
                  ew(32'h9A000000, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0)};
        n_checks++; if (obs_q.size() !== exp_q.size())
            $display("FAIL bp_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            got = 'x; if (i < obs_q.size()) got = obs_q[i];
            n_checks++; if (got !== exp_q[i]) $display("FAIL bp_word%0d got=%h exp=%h", i, got, exp_q[i]); else n_pass++;
        end
        n_checks++; if (stall_viol !== 0) $display("FAIL bp_stable got=%0d exp=0", stall_viol); else n_pass++;
        n_checks++; if (frame_cnt !== 16'd1) $display("FAIL bp_frame_cnt got=%0d exp=1", frame_cnt); else n_pass++;
    endtask

    task automatic test_enable_hold();
        logic [W-1:0] got;
        do_reset();
        TIMESTAMP = 27'h100;
        push_basic_frame();
        tick(6);
        n_checks++; if (fifo_q.size() !== 3) $display("FAIL en_nopop got=%0d exp=3", fifo_q.size()); else n_pass++;
        n_checks++; if (obs_q.size() !== 0) $display("FAIL en_noout got=%0d exp=0", obs_q.size()); else n_pass++;
        enable = 1'b1;
        tick(3);
        enable = 1'b0;
        tick(6);
        n_checks++; if (dbg_state !== ST_FRAME) $display("FAIL en_hold_state got=%0d exp=1", dbg_state); else n_pass++;
        enable = 1'b1;
        tick(30);
        exp_q = '{ew(32'h00000100, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0),
                  ew(32'h12345678, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0),
                  ew(32'h9A000000, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0)};
        n_checks++; if (obs_q.size() !== exp_q.size())
            $display("FAIL en_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            got = 'x; if (i < obs_q.size()) got = obs_q[i];
            n_checks++; if (got !== exp_q[i]) $display("FAIL en_word%0d got=%h exp=%h", i, got, exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_restart();
        logic [W-1:0] got;
        do_reset();
        TIMESTAMP = 27'h200;
        enable = 1'b1;
        push_word(wd(kd(8'hFC), dd(8'h11), dd(8'h22)));
        push_word(wd(dd(8'h33), kd(8'hBC), dd(8'h44)));
        push_word(wd(dd(8'h55), dd(8'h66), dd(8'h77)));
        push_word(wd(kd(8'h7C), kd(8'h3C), kd(8'h3C)));
        tick(40);
        exp_q = '{ew(32'h00000200, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0),
                  ew(32'h11223300, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1),
                  ew(32'h00000200, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0),
                  ew(32'h44556677, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0)};
        n_checks++; if (obs_q.size() !== exp_q.size())
            $display("FAIL restart_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            got = 'x; if (i < obs_q.size()) got = obs_q[i];
            n_checks++; if (got !== exp_q[i]) $display("FAIL restart_word%0d got=%h exp=%h", i, got, exp_q[i]); else n_pass++;
        end
        n_checks++; if (err_cnt !== 8'd1) $display("FAIL restart_err_cnt got=%0d exp=1", err_cnt); else n_pass++;
        n_checks++; if (frame_cnt !== 16'd2) $display("FAIL restart_frame_cnt got=%0d exp=2", frame_cnt); else n_pass++;
    endtask

    task automatic test_truncate();
        logic [W-1:0] got;
        do_reset();
        TIMESTAMP = 27'h0ABCDEF;
        enable = 1'b1;
        push_word(wd(kd(8'hFC), dd(8'h01), dd(8'h02)));
        push_word(wd(dd(8'h03), dd(8'h04), dd(8'h05)));
        push_word(wd(dd(8'h06), dd(8'h07), dd(8'h08)));
        push_word(wd(dd(8'h09), dd(8'h0A), kd(8'h5C)));
        push_word(wd(kd(8'hBC), dd(8'hC1), dd(8'hC2)));
        push_word(wd(kd(8'h5C), kd(8'h3C), kd(8'h3C)));
        tick(50);
        exp_q = '{ew(32'h00ABCDEF, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0),
                  ew(32'h01020304, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0),
                  ew(32'h05060708, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1),
                  ew(32'h00ABCDEF, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0),
                  ew(32'hC1C20000, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0)};
        n_checks++; if (obs_q.size() !== exp_q.size())
            $display("FAIL trunc_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            got = 'x; if (i < obs_q.size()) got = obs_q[i];
            n_checks++; if (got !== exp_q[i]) $display("FAIL trunc_word%0d got=%h exp=%h", i, got, exp_q[i]); else n_pass++;
        end
        n_checks++; if (frame_cnt !== 16'd2) $display("FAIL trunc_frame_cnt got=%0d exp=2", frame_cnt); else n_pass++;
    endtask

    task automatic test_errors();
        do_reset();
        enable = 1'b1;
        push_word(wd(kd(8'h3C), kd(8'h3C), kd(8'h3C)));
        push_word(wd(dd(8'h12), kd(8'h5C), kd(8'h1C)));
        tick(15);
        n_checks++; if (obs_q.size() !== 0) $display("FAIL err_noout got=%0d exp=0", obs_q.size()); else n_pass++;
        n_checks++; if (err_cnt !== 8'd3) $display("FAIL err_cnt3 got=%0d exp=3", err_cnt); else n_pass++;
        n_checks++; if (frame_cnt !== 16'd0) $display("FAIL err_frame_cnt got=%0d exp=0", frame_cnt); else n_pass++;
        for (int i = 0; i < 100; i++) push_word(wd(dd(8'h01), dd(8'h02), dd(8'h03)));
        tick(330);
        n_checks++; if (fifo_q.size() !== 0) $display("FAIL err_drained got=%0d exp=0", fifo_q.size()); else n_pass++;
        n_checks++; if (err_cnt !== 8'hFF) $display("FAIL err_sat got=%0d exp=255", err_cnt); else n_pass++;
        n_checks++; if (obs_q.size() !== 0) $display("FAIL err_noout2 got=%0d exp=0", obs_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [W-1:0] got;
        do_reset();
        TIMESTAMP = 27'h300;
        enable = 1'b1;
        push_word(wd(kd(8'hFC), dd(8'h12), dd(8'h34)));
        tick(8);
        RESET = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_ts !== 1'b0)
            $display("FAIL mid_rst_out got=%b/%h/%b exp=0/0/0", out_valid, out_data, out_ts); else n_pass++;
        n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL mid_rst_state got=%0d exp=0", dbg_state); else n_pass++;
        n_checks++; if (fifo_read !== 1'b0) $display("FAIL mid_rst_read got=%b exp=0", fifo_read); else n_pass++;
        tick(2);
        RESET = 1'b0;
        obs_q.delete();
        tick(1);
        push_word(wd(kd(8'hFC), dd(8'hAB), dd(8'hCD)));
        push_word(wd(dd(8'hEF), dd(8'h01), kd(8'h7C)));
        tick(30);
        exp_q = '{ew(32'h00000300, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0),
                  ew(32'hABCDEF01, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0)};
        n_checks++; if (obs_q.size() !== exp_q.size())
            $display("FAIL mid_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            got = 'x; if (i < obs_q.size()) got = obs_q[i];
            n_checks++; if (got !== exp_q[i]) $display("FAIL mid_word%0d got=%h exp=%h", i, got, exp_q[i]); else n_pass++;
        end
        n_checks++; if (frame_cnt !== 16'd1 || err_cnt !== 8'd0)
            $display("FAIL mid_cnt got=%0d/%0d exp=1/0", frame_cnt, err_cnt); else n_pass++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_enable_hold();
        test_restart();
        test_truncate();
        test_errors();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
